// File: rtl/gradient_conv_unit_if.sv
// Pixel-in / gradient-out stream bundle for gradient_conv_unit.
// The source/sink side takes master, the unit takes slave.
interface gradient_conv_unit_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
);
    logic [CNT_W-1:0]  cfg_width;
    logic              cfg_mode;
    logic [DATA_W-1:0] pix;
    logic              pix_sof;
    logic              pix_val;
    logic              pix_rdy;
    logic [DATA_W+2:0] Ix;
    logic [DATA_W+2:0] Iy;
    logic              out_eol;
    logic              out_val;
    logic              out_rdy;

    modport master (
        output cfg_width, cfg_mode, pix, pix_sof, pix_val, out_rdy,
        input  pix_rdy, Ix, Iy, out_eol, out_val
    );

    modport slave (
        input  cfg_width, cfg_mode, pix, pix_sof, pix_val, out_rdy,
        output pix_rdy, Ix, Iy, out_eol, out_val
    );
endinterface

// File: rtl/gradient_conv_unit.sv
// Streaming 3x3 gradient engine: two line buffers feed a sliding window,
// producing central-difference or Sobel Ix/Iy for every interior pixel.
module gradient_conv_unit #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 64,
    parameter int CNT_W  = 7
) (
    input logic                 clk,
    input logic                 reset,
    gradient_conv_unit_if.slave bus
);
    localparam int OW = DATA_W + 3;
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] TWO = 2;

    typedef struct packed {
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] mid;
        logic [DATA_W-1:0] bot;
    } col_t;

    logic [DATA_W-1:0] lb0 [MAX_W];
    logic [DATA_W-1:0] lb1 [MAX_W];
    col_t [2:0]        win;  // win[0] is the leftmost column
    logic [CNT_W-1:0]  col, row, width;
    logic              mode;

    logic              accept, win_ok, last_col, cur_mode;
    logic [CNT_W-1:0]  cur_col, cur_row, cur_w;
    logic [AW-1:0]     addr;
    col_t              new_col;
    logic signed [OW-1:0] ix_n, iy_n;

    function automatic logic signed [OW-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic signed [OW-1:0] wsum(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        return ext(a) + (ext(b) <<< 1) + ext(c);
    endfunction

    assign bus.pix_rdy = !bus.out_val || bus.out_rdy;
    assign accept      = bus.pix_val && bus.pix_rdy;

    // A sof beat restarts framing and takes the new config for itself.
    always_comb begin
        cur_col  = bus.pix_sof ? '0 : col;
        cur_row  = bus.pix_sof ? '0 : row;
        cur_w    = bus.pix_sof ? bus.cfg_width : width;
        cur_mode = bus.pix_sof ? bus.cfg_mode : mode;
        last_col = (cur_col == cur_w - ONE);
        win_ok   = (cur_row >= TWO) && (cur_col >= TWO);
        addr     = cur_col[AW-1:0];
        new_col  = {lb1[addr], lb0[addr], bus.pix};
    end

    // Kernel sees the window after this beat's shift: left=win[1], mid=win[2].
    always_comb begin
        if (cur_mode) begin
            ix_n = wsum(new_col.top, new_col.mid, new_col.bot)
                 - wsum(win[1].top, win[1].mid, win[1].bot);
            iy_n = wsum(win[1].bot, win[2].bot, new_col.bot)
                 - wsum(win[1].top, win[2].top, new_col.top);
        end else begin
            ix_n = ext(new_col.mid) - ext(win[1].mid);
            iy_n = ext(win[2].bot) - ext(win[2].top);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[addr] <= bus.pix;
            lb1[addr] <= lb0[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            width       <= CNT_W'(MAX_W);
            mode        <= 1'b0;
            win         <= '0;
            bus.out_val <= 1'b0;
            bus.Ix      <= '0;
            bus.Iy      <= '0;
            bus.out_eol <= 1'b0;
        end else begin
            if (accept) begin
                width <= cur_w;
                mode  <= cur_mode;
                win   <= {new_col, win[2], win[1]};
                col   <= last_col ? '0 : cur_col + ONE;
                if (last_col && !(&cur_row))
                    row <= cur_row + ONE;
                else
                    row <= cur_row;
            end
            if (accept && win_ok) begin
                bus.out_val <= 1'b1;
                bus.Ix      <= ix_n;
                bus.Iy      <= iy_n;
                bus.out_eol <= last_col;
            end else if (bus.out_rdy) begin
                bus.out_val <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gradient_conv_unit.sv
// Bench for gradient_conv_unit: image-level reference model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_gradient_conv_unit;
    localparam int DATA_W = 8;
    localparam int MAX_W  = 64;
    localparam int CNT_W  = 7;
    localparam int OW     = DATA_W + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gradient_conv_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    gradient_conv_unit #(.DATA_W(DATA_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [OW-1:0] ix;
        logic [OW-1:0] iy;
        logic          eol;
    } res_t;

    int checks = 0;
    int errors = 0;
    bit force_stall = 1'b0;
    int rdy_pct = 100;

    bit            model_on = 1'b0;
    bit            m_val = 1'b0;
    logic [OW-1:0] m_ix = '0;
    logic [OW-1:0] m_iy = '0;
    bit            m_eol = 1'b0;
    bit            m_mode = 1'b0;
    int            m_r = 0, m_c = 0, m_w = MAX_W;
    int            n_exp = 0;
    int            img [128][64];
    int            rnd [16][16];
    res_t          got [$];
    res_t          ref_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: keep the frame as a 2D image and take gradients around the
    // centre pixel directly from it.
    task automatic model_step();
        int ix, iy, cr, cc;
        if (reset) begin
            model_on = 1'b1;
            m_val = 1'b0; m_ix = '0; m_iy = '0; m_eol = 1'b0;
            m_r = 0; m_c = 0; m_w = MAX_W; m_mode = 1'b0;
        end else if (bus.pix_val && (!m_val || bus.out_rdy)) begin
            if (bus.pix_sof) begin
                m_r = 0; m_c = 0; m_w = int'(bus.cfg_width); m_mode = bus.cfg_mode;
            end
            img[m_r][m_c] = int'(bus.pix);
            if (m_r >= 2 && m_c >= 2) begin
                cr = m_r - 1; cc = m_c - 1;
                ix = 0; iy = 0;
                if (m_mode) begin
                    for (int d = -1; d <= 1; d++) begin
                        ix += ((d == 0) ? 2 : 1) * (img[cr+d][cc+1] - img[cr+d][cc-1]);
                        iy += ((d == 0) ? 2 : 1) * (img[cr+1][cc+d] - img[cr-1][cc+d]);
                    end
                end else begin
                    ix = img[cr][cc+1] - img[cr][cc-1];
                    iy = img[cr+1][cc] - img[cr-1][cc];
                end
                m_ix = ix[OW-1:0];
                m_iy = iy[OW-1:0];
                m_eol = (m_c == m_w - 1);
                m_val = 1'b1;
                n_exp++;
            end else if (bus.out_rdy) begin
                m_val = 1'b0;
            end
            if (m_c == m_w - 1) begin
                m_c = 0;
                if (m_r < 127) m_r++;
            end else begin
                m_c++;
            end
        end else if (bus.out_rdy) begin
            m_val = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            chk("out_val", bus.out_val, m_val);
            chk("pix_rdy", bus.pix_rdy, !m_val || bus.out_rdy);
            if (m_val) begin
                chk("Ix", bus.Ix, m_ix);
                chk("Iy", bus.Iy, m_iy);
                chk("out_eol", bus.out_eol, m_eol);
            end
            if (bus.out_val && bus.out_rdy)
                got.push_back({bus.Ix, bus.Iy, bus.out_eol});
        end
    end

    initial begin
        bus.out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_rdy = force_stall ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        end
    end

    function automatic int pv(input int kind, input int r, input int c);
        case (kind)
            0:       return 10 * c;
            1:       return 5 * r;
            2:       return 200 - 10 * c;
            3:       return (c == 2) ? 255 : 0;
            4:       return (c == 0) ? 255 : 0;
            default: return rnd[r % 16][c % 16];
        endcase
    endfunction

    // Called and returning at posedge+2; leaves pix_val low afterwards.
    task automatic send_pixel(input int p, input bit sof, input int w, input bit md);
        bit acc = 1'b0;
        bus.pix = p[DATA_W-1:0];
        bus.pix_sof = sof;
        bus.cfg_width = w[CNT_W-1:0];
        bus.cfg_mode = md;
        bus.pix_val = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.pix_rdy;
            @(posedge clk);
            #2;
        end
        bus.pix_val = 1'b0;
        bus.pix_sof = 1'b0;
        chk("accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input int w, input int h, input bit md, input int kind,
                              input int nbeats, input bit gaps);
        for (int k = 0; k < w * h; k++) begin
            if (nbeats >= 0 && k >= nbeats) break;
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #2; end
            send_pixel(pv(kind, k / w, k % w), k == 0, w, md);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && bus.out_val; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", bus.out_val, 0);
    endtask

    task automatic stall_frame(input bit stall);
        for (int k = 0; k < 25; k++) begin
            if (stall && k == 12) force_stall = 1'b1;
            if (stall && k == 13) begin
                bus.pix = pv(5, 2, 3);
                bus.pix_sof = 1'b0;
                bus.pix_val = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_pix_rdy", bus.pix_rdy, 0);
                    chk("stall_out_val", bus.out_val, 1);
                    @(posedge clk);
                    #2;
                end
                force_stall = 1'b0;
            end
            send_pixel(pv(5, k / 5, k % 5), k == 0, 5, 1'b0);
        end
    endtask

    task automatic fill_rnd();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                rnd[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        int base;
        bus.pix = '0; bus.pix_sof = 1'b0; bus.pix_val = 1'b0;
        bus.cfg_width = 7'd4; bus.cfg_mode = 1'b0;
        fill_rnd();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        chk("rst_out_val", bus.out_val, 0);
        chk("rst_Ix", bus.Ix, 0);
        chk("rst_Iy", bus.Iy, 0);
        chk("rst_eol", bus.out_eol, 0);
        chk("rst_pix_rdy", bus.pix_rdy, 1);

        // central difference, horizontal ramp
        got.delete();
        send_frame(4, 4, 1'b0, 0, -1, 1'b0);
        drain();
        chk("t1_count", got.size(), 4);
        foreach (got[i]) begin
            chk("t1_Ix", got[i].ix, 20);
            chk("t1_Iy", got[i].iy, 0);
            chk("t1_eol", got[i].eol, (i % 2 == 1));
        end

        // vertical ramp, then falling horizontal ramp
        got.delete();
        send_frame(5, 5, 1'b0, 1, -1, 1'b0);
        drain();
        chk("t2a_count", got.size(), 9);
        foreach (got[i]) begin
            chk("t2a_Ix", got[i].ix, 0);
            chk("t2a_Iy", got[i].iy, 10);
        end
        got.delete();
        send_frame(5, 5, 1'b0, 2, -1, 1'b0);
        drain();
        chk("t2b_count", got.size(), 9);
        foreach (got[i]) begin
            chk("t2b_Ix", got[i].ix, 11'h7EC);
            chk("t2b_Iy", got[i].iy, 0);
            chk("t2b_eol", got[i].eol, (i % 3 == 2));
        end

        // Sobel ramp and full-scale edges
        got.delete();
        send_frame(4, 4, 1'b1, 0, -1, 1'b0);
        drain();
        chk("t3a_count", got.size(), 4);
        foreach (got[i]) chk("t3a_Ix", got[i].ix, 80);
        got.delete();
        send_frame(3, 3, 1'b1, 3, -1, 1'b0);
        send_frame(3, 3, 1'b1, 4, -1, 1'b0);
        drain();
        chk("t3b_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3b_Ix_pos", got[0].ix, 11'h3FC);
            chk("t3b_Iy_pos", got[0].iy, 0);
            chk("t3b_Ix_neg", got[1].ix, 11'h404);
            chk("t3b_Iy_neg", got[1].iy, 0);
        end

        // stall must not change the result stream
        fill_rnd();
        got.delete();
        stall_frame(1'b0);
        drain();
        ref_q = got;
        chk("t4_ref_count", ref_q.size(), 9);
        got.delete();
        stall_frame(1'b1);
        drain();
        chk("t4_count", got.size(), ref_q.size());
        if (got.size() == ref_q.size())
            foreach (got[i]) chk("t4_seq", got[i], ref_q[i]);

        // width and mode change across frames
        got.delete();
        send_frame(3, 3, 1'b0, 5, -1, 1'b0);
        send_frame(6, 3, 1'b1, 5, -1, 1'b0);
        drain();
        chk("t5_count", got.size(), 5);
        if (got.size() == 5)
            foreach (got[i]) chk("t5_eol", got[i].eol, (i == 0 || i == 4));

        // reset mid-frame
        send_frame(4, 4, 1'b0, 0, 7, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("t6_out_val", bus.out_val, 0);
        chk("t6_Ix", bus.Ix, 0);
        chk("t6_Iy", bus.Iy, 0);
        chk("t6_eol", bus.out_eol, 0);
        reset = 1'b0;
        got.delete();
        send_frame(4, 4, 1'b0, 0, -1, 1'b0);
        drain();
        chk("t6_count", got.size(), 4);
        foreach (got[i]) chk("t6_Ix_frame", got[i].ix, 20);

        // random frames, widths, modes, backpressure and abandoned frames
        rdy_pct = 60;
        got.delete();
        base = n_exp;
        for (int f = 0; f < 10; f++) begin
            int w, h, nb;
            fill_rnd();
            w = (f == 0) ? MAX_W : int'($urandom_range(3, 12));
            h = int'($urandom_range(3, 6));
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, w * h - 1)) : -1;
            send_frame(w, h, 1'($urandom_range(0, 1)), 5, nb, 1'b1);
        end
        rdy_pct = 100;
        drain();
        chk("rand_count", got.size(), n_exp - base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
